// File: rtl/mure_pkg.sv
// Shared types for the trace debugger front end: data width, commit window
// slot layout and the window sequencing states.
package mure_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILL    = 2'd1,
        RUN     = 2'd2,
        DRAINED = 2'd3
    } win_state_e;

    typedef struct packed {
        logic [XLEN-1:0] iaddr;
        logic [XLEN-1:0] inst_data;
        logic            compressed;
        logic            exception;
        logic            interrupt;
        logic            eret;
        logic            valid;
    } win_slot_t;

endpackage

// File: rtl/trdb_commit_window.sv
// Three-slot commit window (previous / current / next) in front of the itype
// detector; an idle timer pushes the newest entry into the current slot.
//
// state   | meaning
// EMPTY   | no entry since reset or flush
// FILL    | next slot loaded, current slot not yet valid
// RUN     | current slot valid, window advancing on accepts
// DRAINED | newest entry forced into current slot, next slot empty
module trdb_commit_window
    import mure_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] iaddr_i,
    input  logic [XLEN-1:0] inst_data_i,
    input  logic            compressed_i,
    input  logic            exception_i,
    input  logic            interrupt_i,
    input  logic            eret_i,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic            pc_valid_o,
    output logic            cc_valid_o,
    output logic            nc_valid_o,
    output logic [XLEN-1:0] pc_iaddr_o,
    output logic [XLEN-1:0] cc_iaddr_o,
    output logic [XLEN-1:0] nc_iaddr_o,
    output logic [XLEN-1:0] cc_inst_data_o,
    output logic            cc_compressed_o,
    output logic            cc_exception_o,
    output logic            cc_interrupt_o,
    output logic            cc_eret_o,
    output logic            cc_fresh_o
);

    localparam int unsigned      CNT_W    = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] DRAIN_TC = CNT_W'(DRAIN_CYCLES);

    win_state_e       state_q, state_d;
    win_slot_t        pc_q, cc_q, nc_q;
    win_slot_t        pc_d, cc_d, nc_d;
    win_slot_t        in_slot;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             cc_fresh_q, cc_fresh_d;
    logic             accept;
    logic             drain;

    assign ready_o = !stall_i && !flush_i;
    assign accept  = valid_i && ready_o;
    // Accept always wins over a drain that happens to time out in the same cycle.
    assign drain   = ready_o && !valid_i && nc_q.valid && (idle_cnt_q == DRAIN_TC);

    assign in_slot = '{
        iaddr:      iaddr_i,
        inst_data:  inst_data_i,
        compressed: compressed_i,
        exception:  exception_i,
        interrupt:  interrupt_i,
        eret:       eret_i,
        valid:      1'b1
    };

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else if (!stall_i) begin
            case (state_q)
                EMPTY: begin
                    if (accept) state_d = FILL;
                end
                FILL: begin
                    if (drain)                   state_d = DRAINED;
                    else if (accept && nc_q.valid) state_d = RUN;
                end
                RUN: begin
                    if (drain) state_d = DRAINED;
                end
                DRAINED: begin
                    if (accept) state_d = RUN;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Emptied slots are written as all-zero, so an invalid slot never
    // carries stale address or attribute bits forward.
    always_comb begin
        pc_d       = pc_q;
        cc_d       = cc_q;
        nc_d       = nc_q;
        idle_cnt_d = idle_cnt_q;
        cc_fresh_d = 1'b0;
        if (flush_i) begin
            pc_d       = '0;
            cc_d       = '0;
            nc_d       = '0;
            idle_cnt_d = '0;
        end else if (stall_i) begin
            idle_cnt_d = idle_cnt_q;
        end else if (accept) begin
            pc_d       = cc_q;
            cc_d       = nc_q;
            nc_d       = in_slot;
            idle_cnt_d = '0;
            cc_fresh_d = nc_q.valid;
        end else if (drain) begin
            pc_d       = cc_q;
            cc_d       = nc_q;
            nc_d       = '0;
            idle_cnt_d = '0;
            cc_fresh_d = 1'b1;
        end else if (nc_q.valid && (idle_cnt_q != DRAIN_TC)) begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q       <= '0;
            cc_q       <= '0;
            nc_q       <= '0;
            idle_cnt_q <= '0;
            cc_fresh_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            cc_q       <= cc_d;
            nc_q       <= nc_d;
            idle_cnt_q <= idle_cnt_d;
            cc_fresh_q <= cc_fresh_d;
        end
    end

    assign pc_valid_o      = pc_q.valid;
    assign cc_valid_o      = cc_q.valid;
    assign nc_valid_o      = nc_q.valid;
    assign pc_iaddr_o      = pc_q.iaddr;
    assign cc_iaddr_o      = cc_q.iaddr;
    assign nc_iaddr_o      = nc_q.iaddr;
    assign cc_inst_data_o  = cc_q.inst_data & {XLEN{cc_q.valid}};
    assign cc_compressed_o = cc_q.compressed & cc_q.valid;
    assign cc_exception_o  = cc_q.exception & cc_q.valid;
    assign cc_interrupt_o  = cc_q.interrupt & cc_q.valid;
    assign cc_eret_o       = cc_q.eret & cc_q.valid;
    assign cc_fresh_o      = cc_fresh_q;

    // The previous slot keeps its full payload for the detector's history,
    // but only its address and valid leave this block.
    logic unused_pc_payload;
    assign unused_pc_payload = ^{pc_q.inst_data, pc_q.compressed, pc_q.exception,
                                 pc_q.interrupt, pc_q.eret};

endmodule

// File: tb/tb_trdb_commit_window.sv
// Scoreboard bench for the commit window: a queue-based reference model
// predicts every cycle, a separate monitor compares registered outputs.
module tb_trdb_commit_window;
    import mure_pkg::*;

    localparam int unsigned DRAIN = 8;
    localparam int          OW    = 3 + 4 * XLEN + 5;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            valid_i = 1'b0;
    logic            ready_o;
    logic [XLEN-1:0] iaddr_i = '0;
    logic [XLEN-1:0] inst_data_i = '0;
    logic            compressed_i = 1'b0;
    logic            exception_i = 1'b0;
    logic            interrupt_i = 1'b0;
    logic            eret_i = 1'b0;
    logic            stall_i = 1'b0;
    logic            flush_i = 1'b0;
    logic            pc_valid_o, cc_valid_o, nc_valid_o;
    logic [XLEN-1:0] pc_iaddr_o, cc_iaddr_o, nc_iaddr_o, cc_inst_data_o;
    logic            cc_compressed_o, cc_exception_o, cc_interrupt_o, cc_eret_o;
    logic            cc_fresh_o;

    trdb_commit_window #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .iaddr_i(iaddr_i), .inst_data_i(inst_data_i), .compressed_i(compressed_i),
        .exception_i(exception_i), .interrupt_i(interrupt_i), .eret_i(eret_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .pc_valid_o(pc_valid_o), .cc_valid_o(cc_valid_o), .nc_valid_o(nc_valid_o),
        .pc_iaddr_o(pc_iaddr_o), .cc_iaddr_o(cc_iaddr_o), .nc_iaddr_o(nc_iaddr_o),
        .cc_inst_data_o(cc_inst_data_o), .cc_compressed_o(cc_compressed_o),
        .cc_exception_o(cc_exception_o), .cc_interrupt_o(cc_interrupt_o),
        .cc_eret_o(cc_eret_o), .cc_fresh_o(cc_fresh_o)
    );

    always #5 clk_i = ~clk_i;

    logic [OW-1:0] dut_outs;
    assign dut_outs = {pc_valid_o, cc_valid_o, nc_valid_o, pc_iaddr_o, cc_iaddr_o,
                       nc_iaddr_o, cc_inst_data_o, cc_compressed_o, cc_exception_o,
                       cc_interrupt_o, cc_eret_o, cc_fresh_o};

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] d;
        logic c, e, i, r, v;
    } ent_t;

    typedef struct {
        logic [OW-1:0] outs;
        logic [1:0]    st;
        bit            rdy;
        int            n;
    } exp_t;

    // Reference window: index 0 = previous, 1 = current, 2 = next.
    ent_t       win [3];
    int         m_idle;
    bit         m_fresh;
    win_state_e m_st;
    exp_t       sb_q[$];
    int         n_vec = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [XLEN-1:0] prev_a = '0;

    function automatic logic [OW-1:0] model_outs();
        return {win[0].v, win[1].v, win[2].v, win[0].a, win[1].a, win[2].a,
                win[1].d, win[1].c, win[1].e, win[1].i, win[1].r, m_fresh};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) win[k] = '0;
        m_idle  = 0;
        m_fresh = 1'b0;
        m_st    = EMPTY;
    endtask

    task automatic shift_in(input ent_t e);
        win[0] = win[1];
        win[1] = win[2];
        win[2] = e;
    endtask

    task automatic model_step(input bit v, input ent_t e, input bit st, input bit fl);
        bit old_nc;
        old_nc = win[2].v;
        if (fl) begin
            model_reset();
        end else if (st) begin
            m_fresh = 1'b0;
        end else if (v) begin
            shift_in(e);
            m_fresh = old_nc;
            m_idle  = 0;
            if (m_st == EMPTY) m_st = FILL;
            else if (m_st == DRAINED || (m_st == FILL && old_nc)) m_st = RUN;
        end else if (old_nc && m_idle == int'(DRAIN)) begin
            shift_in('0);
            m_fresh = 1'b1;
            m_idle  = 0;
            m_st    = DRAINED;
        end else begin
            m_fresh = 1'b0;
            if (old_nc && m_idle < int'(DRAIN)) m_idle++;
        end
    endtask

    task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic push_exp(input bit rdy);
        exp_t x;
        x.outs = model_outs();
        x.st   = m_st;
        x.rdy  = rdy;
        x.n    = cyc;
        sb_q.push_back(x);
    endtask

    task automatic cycle(input bit v, input logic [XLEN-1:0] a, input bit c,
                         input bit st, input bit fl);
        ent_t e;
        @(negedge clk_i);
        rst_ni       = 1'b1;
        cyc++;
        e.a = a;
        e.d = $urandom;
        e.c = c;
        e.e = 1'($urandom_range(0, 1));
        e.i = 1'($urandom_range(0, 1));
        e.r = 1'($urandom_range(0, 1));
        e.v = 1'b1;
        valid_i      = v;
        iaddr_i      = e.a;
        inst_data_i  = e.d;
        compressed_i = e.c;
        exception_i  = e.e;
        interrupt_i  = e.i;
        eret_i       = e.r;
        stall_i      = st;
        flush_i      = fl;
        model_step(v, e, st, fl);
        push_exp(!st && !fl);
    endtask

    task automatic reset_cycle();
        @(negedge clk_i);
        cyc++;
        valid_i = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        model_reset();
        push_exp(1'b1);
        #1 rst_ni = 1'b0;
        #1 check("async_reset_outs", dut_outs, '0);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, $urandom, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk_i);
            #1;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                check($sformatf("c%0d_outs", x.n), dut_outs, x.outs);
                check($sformatf("c%0d_ready", x.n), OW'(ready_o), OW'(x.rdy));
                check($sformatf("c%0d_state", x.n), OW'(dut.state_q), OW'(x.st));
            end
        end
    end

    initial begin : driver
        int mode, len;
        bit v;
        model_reset();
        repeat (2) @(negedge clk_i);
        check("reset_outs", dut_outs, '0);
        check("reset_state", OW'(dut.state_q), OW'(EMPTY));

        // three back-to-back accepts
        cycle(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h108, 1'b0, 1'b0, 1'b0);
        idle(2);

        // single entry then drain timeout, no second drain
        cycle(1'b0, $urandom, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        idle(DRAIN + 6);

        // stall with valid held high in RUN
        cycle(1'b1, 32'h210, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h214, 1'b0, 1'b0, 1'b0);
        idle(3);
        repeat (5) cycle(1'b1, 32'h218, 1'b0, 1'b1, 1'b0);
        idle(2);

        // flush beats accept
        cycle(1'b1, 32'h220, 1'b0, 1'b0, 1'b1);
        idle(1);

        // compressed branch reaches the current slot
        cycle(1'b1, 32'h300, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h340, 1'b0, 1'b0, 1'b0);
        idle(1);

        // reset while full, then first accept lands in next slot only
        cycle(1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h404, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h408, 1'b0, 1'b0, 1'b0);
        reset_cycle();
        cycle(1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
        idle(1);

        for (int b = 0; b < 300; b++) begin
            mode = int'($urandom_range(0, 9));
            if (mode <= 4) begin
                len = int'($urandom_range(1, 6));
                repeat (len) begin
                    v = ($urandom_range(0, 3) != 0);
                    if ($urandom_range(0, 3) != 0) prev_a = $urandom;
                    cycle(v, prev_a, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0), 1'b0);
                end
            end else if (mode <= 6) begin
                idle(int'($urandom_range(1, 12)));
            end else if (mode == 7) begin
                len = int'($urandom_range(1, 4));
                repeat (len) cycle(1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b1, 1'b0);
            end else if (mode == 8) begin
                if ($urandom_range(0, 2) == 0) reset_cycle();
                else cycle(1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b0, 1'b1);
            end else begin
                cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
            end
        end

        for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(posedge clk_i);
        #2;
        n_vec++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/trdb_commit_window.md
TRDB_COMMIT_WINDOW -- requirements
Module: trdb_commit_window

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 8: consecutive idle cycles before the newest entry is forced into the current slot.
REQ-002 SHALL have port clk_i  in  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports valid_i  in  1 (committed-instruction valid) and ready_o  out  1 (window accepts).
REQ-005 SHALL have ports iaddr_i  in  XLEN (address) and inst_data_i  in  XLEN (encoding).
REQ-006 SHALL have ports compressed_i, exception_i, interrupt_i, eret_i  in  1 each; these are instruction attributes.
REQ-007 SHALL have ports stall_i  in  1 (downstream backpressure) and flush_i  in  1 (discard window).
REQ-008 SHALL have ports pc_valid_o, cc_valid_o, nc_valid_o  out  1 each; these are slot valids.
REQ-009 SHALL have ports pc_iaddr_o, cc_iaddr_o, nc_iaddr_o  out  XLEN each; these are slot addresses.
REQ-010 SHALL have ports cc_inst_data_o  out  XLEN and cc_compressed_o, cc_exception_o, cc_interrupt_o, cc_eret_o  out  1; these are current-slot attributes.
REQ-011 SHALL have port cc_fresh_o  out  1; it pulses one cycle when a new entry lands in the current slot.

Function
REQ-012 SHALL hold a three-slot shift window: previous (pc), current (cc), next (nc); each slot stores address, data, attributes and valid.
REQ-013 SHALL drive ready_o = !stall_i && !flush_i, combinationally.
REQ-014 SHALL shift on accept (valid_i && ready_o): pc<=cc, cc<=nc, nc<=input with nc valid=1.
REQ-015 SHALL set cc_fresh_o the cycle after any shift whose old nc slot was valid.
REQ-016 SHALL give latency: an entry accepted at cycle N appears in nc at N+1 and in cc, with cc_fresh_o=1, at the cycle after the next shift.
REQ-017 SHALL implement the FSM states EMPTY, FILL, RUN, DRAINED.
REQ-018 SHALL perform these FSM transitions: EMPTY->FILL on accept; FILL->RUN when cc becomes valid; RUN->DRAINED on a drain shift; DRAINED->RUN on accept.
REQ-019 SHALL keep a saturating idle counter of width $clog2(DRAIN_CYCLES+1); it resets to 0 on accept and increments each cycle nc is valid, no accept occurs and stall_i=0.
REQ-020 SHALL perform a drain shift when the counter reaches DRAIN_CYCLES: pc<=cc, cc<=nc, nc valid<=0, counter<=0, and cc_fresh_o pulses next cycle.
REQ-021 SHALL perform no drain shift when nc is invalid, and SHALL never drain twice without an intervening accept.
REQ-022 SHALL freeze all slots, the counter and the FSM while stall_i=1; cc_fresh_o SHALL be 0 during stall.
REQ-023 SHALL, on flush_i=1, clear every slot valid, the counter and cc_fresh_o next cycle and go to EMPTY; flush wins over accept and drain (ready_o=0).
REQ-024 SHALL keep cc attribute outputs at 0 whenever cc_valid_o=0.
REQ-025 SHALL allow back-to-back accepts every cycle with no bubble; equal consecutive addresses are legal and are shifted as distinct entries.
REQ-026 SHALL present all outputs directly from registers, with no combinational input-to-output paths except ready_o.

Reset
REQ-027 SHALL, on reset assertion, asynchronously clear all slot valids, addresses, data, attributes, the counter and cc_fresh_o to 0, and set the FSM to EMPTY.
REQ-028 SHALL, on reset assertion mid-stream, lose all in-flight entries; the first accept after release SHALL behave as from EMPTY.

Structure
REQ-029 SHALL take XLEN from mure_pkg and SHALL add the state enum win_state_e {EMPTY, FILL, RUN, DRAINED} to mure_pkg.
REQ-030 SHALL add a slot struct win_slot_t (iaddr, inst_data, compressed, exception, interrupt, eret, valid) to mure_pkg.
REQ-031 SHALL be a single module with no sub-module; the window output feeds the itype detector inputs directly.

Verification
REQ-032 SHALL cover this case: accept 0x100, 0x104, 0x108 on consecutive cycles -> cycle 4: pc=0x100, cc=0x104, nc=0x108, all valid, and cc_fresh_o=1 at cycles 3 and 4.
REQ-033 SHALL cover this case: accept 0x200, then idle with DRAIN_CYCLES=8 -> 8 idle cycles after nc fills, cc=0x200, nc_valid_o=0, one cc_fresh_o pulse, state DRAINED, no second drain.
REQ-034 SHALL cover this case: stall_i=1 for 5 cycles in RUN with valid_i=1 -> ready_o=0, slots unchanged, no cc_fresh_o, and the idle counter held.
REQ-035 SHALL cover this case: flush_i and valid_i both high in RUN -> ready_o=0, next cycle all valids 0, state EMPTY, entry not captured.
REQ-036 SHALL cover this case: accept branch 0x300 (compressed_i=1) then 0x340 -> when 0x300 is in cc, cc_compressed_o=1, nc=0x340, cc_fresh_o=1.
REQ-037 SHALL cover this case: rst_ni low for 1 cycle while full in RUN -> all outputs 0 immediately, and the first accept afterwards lands in nc only.
